// File: rtl/sram_sync_fifo.sv
// FWFT FIFO controller in front of an external SRAM with registered read; a 2-entry
// prefetch buffer hides the read latency. Optional FIFO_SYNC_SRAM_BYPASS_EN writes into the buffer directly.
module sram_sync_fifo #(
  parameter int FIFO_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 64,
  parameter int FIFO_CNT_WID = 7,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_init,
  input  logic                    fifo_push,
  input  logic [FIFO_WIDTH-1:0]   fifo_data_in,
  output logic                    fifo_full,
  output logic                    fifo_afull,
  input  logic                    fifo_pop,
  output logic [FIFO_WIDTH-1:0]   fifo_data_out,
  output logic                    fifo_empty,
  output logic [FIFO_CNT_WID-1:0] fifo_word_cnt,
  output logic                    sram_we,
  output logic [FIFO_CNT_WID-2:0] sram_waddr,
  output logic [FIFO_WIDTH-1:0]   sram_wdata,
  output logic                    sram_re,
  output logic [FIFO_CNT_WID-2:0] sram_raddr,
  input  logic [FIFO_WIDTH-1:0]   sram_rdata
);

  localparam int CW = FIFO_CNT_WID;
  localparam int AW = FIFO_CNT_WID - 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(FIFO_DEPTH - AFULL_MARGIN);

  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         sram_cnt, word_cnt, word_cnt_nxt, sram_cnt_nxt;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] pf0, pf1, pf0_nxt, pf1_nxt, app_data;
  logic [1:0]            pf_cnt, pf_cnt_nxt;
  logic                  full_q, afull_q;
  logic                  push_ok, pop_ok, rd_en, byp, wr_en;
  logic [2:0]            pend, lim;

  assign push_ok = fifo_push & ~full_q;
  assign pop_ok  = fifo_pop & (pf_cnt != 2'd0);

  // Reads are issued only while the buffer is guaranteed a slot when the data lands.
  assign pend  = {1'b0, pf_cnt} + {2'b00, inflight};
  assign lim   = 3'd2 + {2'b00, pop_ok};
  assign rd_en = (sram_cnt != '0) && (pend < lim);

`ifdef FIFO_SYNC_SRAM_BYPASS_EN
  assign byp = push_ok && (sram_cnt == '0) && !inflight && ({1'b0, pf_cnt} < lim);
`else
  assign byp = 1'b0;
`endif

  assign wr_en = push_ok & ~byp;

  always_comb begin
    pf0_nxt    = pf0;
    pf1_nxt    = pf1;
    pf_cnt_nxt = pf_cnt;
    app_data   = inflight ? sram_rdata : fifo_data_in;
    if (pop_ok) begin
      pf0_nxt    = pf1;
      pf_cnt_nxt = pf_cnt - 2'd1;
    end
    if (inflight || byp) begin
      if (pf_cnt_nxt == 2'd0) pf0_nxt = app_data;
      else                    pf1_nxt = app_data;
      pf_cnt_nxt = pf_cnt_nxt + 2'd1;
    end
  end

  assign word_cnt_nxt = word_cnt + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop_ok};
  assign sram_cnt_nxt = sram_cnt + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, rd_en};

  always_ff @(posedge clk) begin
    if (rst_n || fifo_init) begin
      wptr     <= '0;
      rptr     <= '0;
      sram_cnt <= '0;
      word_cnt <= '0;
      inflight <= 1'b0;
      pf0      <= '0;
      pf1      <= '0;
      pf_cnt   <= 2'd0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      sram_cnt <= sram_cnt_nxt;
      word_cnt <= word_cnt_nxt;
      inflight <= rd_en;
      pf0      <= pf0_nxt;
      pf1      <= pf1_nxt;
      pf_cnt   <= pf_cnt_nxt;
      full_q   <= (word_cnt_nxt == FULL_CNT);
      afull_q  <= (word_cnt_nxt >= AFULL_CNT);
    end
  end

  assign fifo_full     = full_q;
  assign fifo_afull    = afull_q;
  assign fifo_empty    = (pf_cnt == 2'd0);
  assign fifo_data_out = pf0;
  assign fifo_word_cnt = word_cnt;
  assign sram_we       = wr_en;
  assign sram_waddr    = wptr;
  assign sram_wdata    = fifo_data_in;
  assign sram_re       = rd_en;
  assign sram_raddr    = rptr;

endmodule

// File: tb/tb_sram_sync_fifo.sv
// Self-checking bench for sram_sync_fifo with a behavioural registered-read SRAM.
// Expectations adapt to FIFO_SYNC_SRAM_BYPASS_EN when that macro is defined.
module tb_sram_sync_fifo;
  localparam int W = 64;
`ifdef FIFO_SYNC_SRAM_BYPASS_EN
  localparam int BYP = 2;
`else
  localparam int BYP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, fifo_init, fifo_push, fifo_pop;
  logic [W-1:0] fifo_data_in, fifo_data_out, sram_wdata, sram_rdata;
  logic fifo_full, fifo_afull, fifo_empty, sram_we, sram_re;
  logic [6:0] fifo_word_cnt;
  logic [5:0] sram_waddr, sram_raddr;
  logic [W-1:0] mem [64];

  int errs = 0;
  int checks = 0;

  sram_sync_fifo dut (
    .clk(clk), .rst_n(rst_n), .fifo_init(fifo_init), .fifo_push(fifo_push),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
    .fifo_pop(fifo_pop), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_word_cnt(fifo_word_cnt), .sram_we(sram_we), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .sram_re(sram_re), .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_we) mem[sram_waddr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_raddr];
  end

  typedef struct {
    logic       push;
    logic       pop;
    logic [W-1:0] din;
    logic       we;
    logic       re;
    int         cnt;
    logic       empty;
    logic [W-1:0] dout;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fifo_push = 1'b0; fifo_pop = 1'b0; fifo_init = 1'b0; rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic pop_n(input int n, input logic [W-1:0] first_val, input string nm);
    int got = 0;
    for (int c = 0; c < n * 4 + 20 && got < n; c++) begin
      fifo_pop = !fifo_empty;
      if (fifo_pop) begin
        chk(nm, fifo_data_out, first_val + W'(got));
        got++;
      end
      tick();
    end
    fifo_pop = 1'b0;
    chk({nm, "_count"}, W'(got), W'(n));
  endtask

  task automatic midop(input logic use_init);
    int waited = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fifo_push = 1'b1; fifo_data_in = W'(32'h400 + i);
      tick();
    end
    fifo_push = 1'b0;
    repeat (3) tick();
    fifo_pop = 1'b1;
    #1 chk("midop_re", W'(sram_re), 1);
    tick();
    fifo_pop = 1'b0;
    if (use_init) fifo_init = 1'b1; else rst_n = 1'b1;
    tick();
    fifo_init = 1'b0; rst_n = 1'b0;
    chk("midop_empty", W'(fifo_empty), 1);
    chk("midop_cnt", W'(fifo_word_cnt), 0);
    chk("midop_waddr", W'(sram_waddr), 0);
    chk("midop_raddr", W'(sram_raddr), 0);
    tick(); tick();
    chk("midop_drop", W'(fifo_empty), 1);
    fifo_push = 1'b1; fifo_data_in = 64'h77;
    tick();
    fifo_push = 1'b0;
    while (fifo_empty && waited < 10) begin
      tick();
      waited++;
    end
    chk("midop_visible", W'(fifo_empty), 0);
    chk("midop_first", fifo_data_out, 64'h77);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    chk("midop_after_empty", W'(fifo_empty), 1);
    chk("midop_after_cnt", W'(fifo_word_cnt), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int exp_rd;
    logic saw_full;

`ifdef FIFO_SYNC_SRAM_BYPASS_EN
    vt[0] = '{1'b1, 1'b0, 64'h100, 1'b0, 1'b0, 1, 1'b0, 64'h100};
    vt[1] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 1, 1'b0, 64'h100};
    vt[2] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 1, 1'b0, 64'h100};
    vt[3] = '{1'b1, 1'b0, 64'h101, 1'b0, 1'b0, 2, 1'b0, 64'h100};
    vt[4] = '{1'b0, 1'b1, 64'h0,   1'b0, 1'b0, 1, 1'b0, 64'h101};
    vt[5] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 1, 1'b0, 64'h101};
    vt[6] = '{1'b1, 1'b1, 64'h102, 1'b0, 1'b0, 1, 1'b0, 64'h102};
    vt[7] = '{1'b0, 1'b1, 64'h0,   1'b0, 1'b0, 0, 1'b1, 64'h0};
    vt[8] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 0, 1'b1, 64'h0};
    vt[9] = '{1'b0, 1'b1, 64'h0,   1'b0, 1'b0, 0, 1'b1, 64'h0};
`else
    vt[0] = '{1'b1, 1'b0, 64'h100, 1'b1, 1'b0, 1, 1'b1, 64'h0};
    vt[1] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b1, 1, 1'b1, 64'h0};
    vt[2] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 1, 1'b0, 64'h100};
    vt[3] = '{1'b1, 1'b0, 64'h101, 1'b1, 1'b0, 2, 1'b0, 64'h100};
    vt[4] = '{1'b0, 1'b1, 64'h0,   1'b0, 1'b1, 1, 1'b1, 64'h0};
    vt[5] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 1, 1'b0, 64'h101};
    vt[6] = '{1'b1, 1'b1, 64'h102, 1'b1, 1'b0, 1, 1'b1, 64'h0};
    vt[7] = '{1'b0, 1'b1, 64'h0,   1'b0, 1'b1, 1, 1'b1, 64'h0};
    vt[8] = '{1'b0, 1'b0, 64'h0,   1'b0, 1'b0, 1, 1'b0, 64'h102};
    vt[9] = '{1'b0, 1'b1, 64'h0,   1'b0, 1'b0, 0, 1'b1, 64'h0};
`endif

    fifo_data_in = '0;
    do_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("rst_empty", W'(fifo_empty), 1);
    chk("rst_full", W'(fifo_full), 0);
    chk("rst_afull", W'(fifo_afull), 0);
    chk("rst_cnt", W'(fifo_word_cnt), 0);
    chk("rst_dout", fifo_data_out, 0);
    chk("rst_re", W'(sram_re), 0);
    chk("rst_raddr", W'(sram_raddr), 0);
    chk("rst_waddr", W'(sram_waddr), 0);

    for (int i = 0; i < 10; i++) begin
      fifo_push = vt[i].push; fifo_pop = vt[i].pop; fifo_data_in = vt[i].din;
      #1;
      chk($sformatf("tbl%0d_we", i), W'(sram_we), W'(vt[i].we));
      chk($sformatf("tbl%0d_re", i), W'(sram_re), W'(vt[i].re));
      tick();
      chk($sformatf("tbl%0d_cnt", i), W'(fifo_word_cnt), W'(vt[i].cnt));
      chk($sformatf("tbl%0d_empty", i), W'(fifo_empty), W'(vt[i].empty));
      if (!vt[i].empty) chk($sformatf("tbl%0d_dout", i), fifo_data_out, vt[i].dout);
    end
    fifo_push = 1'b0; fifo_pop = 1'b0;

    // stream
    do_reset();
    first = -1; exp_rd = 0; saw_full = 1'b0;
    for (int i = 0; i < 100; i++) begin
      fifo_push = 1'b1; fifo_data_in = W'(i);
      fifo_pop = !fifo_empty;
      if (fifo_pop) begin
        if (first < 0) first = i;
        chk("stream_data", fifo_data_out, W'(exp_rd));
        exp_rd++;
      end
      if (fifo_full) saw_full = 1'b1;
      tick();
    end
    fifo_push = 1'b0;
    chk("stream_first", W'(first), W'((BYP != 0) ? 1 : 3));
    chk("stream_popped", W'(exp_rd), W'((BYP != 0) ? 99 : 97));
    chk("stream_no_full", W'(saw_full), 0);
    pop_n(100 - exp_rd, W'(exp_rd), "stream_drain");
    chk("stream_end_cnt", W'(fifo_word_cnt), 0);

    // fill to full
    do_reset();
    for (int i = 0; i < 64; i++) begin
      fifo_push = 1'b1; fifo_data_in = W'(32'h200 + i);
      tick();
      chk("fill_cnt", W'(fifo_word_cnt), W'(i + 1));
      chk("fill_afull", W'(fifo_afull), W'(i + 1 >= 60));
      chk("fill_full", W'(fifo_full), W'(i + 1 == 64));
    end
    fifo_data_in = 64'hdead;
    #1 chk("full_push_we", W'(sram_we), 0);
    tick();
    chk("full_push_cnt", W'(fifo_word_cnt), 64);
    chk("full_push_waddr", W'(sram_waddr), W'((64 - BYP) % 64));
    fifo_data_in = 64'hbeef; fifo_pop = 1'b1;
    #1 chk("full_pp_we", W'(sram_we), 0);
    chk("full_pp_head", fifo_data_out, 64'h200);
    tick();
    fifo_push = 1'b0; fifo_pop = 1'b0;
    chk("full_pp_cnt", W'(fifo_word_cnt), 63);
    chk("full_pp_full", W'(fifo_full), 0);
    chk("full_pp_afull", W'(fifo_afull), 1);
    pop_n(63, 64'h201, "fill_drain");
    chk("fill_end_empty", W'(fifo_empty), 1);
    chk("fill_end_cnt", W'(fifo_word_cnt), 0);

    // wrap
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) begin
        fifo_push = 1'b1; fifo_data_in = W'(32'h300 + r * 40 + i);
        tick();
      end
      fifo_push = 1'b0;
      pop_n(40, W'(32'h300 + r * 40), "wrap_data");
      chk("wrap_waddr", W'(sram_waddr), W'(((r + 1) * (40 - BYP)) % 64));
      chk("wrap_raddr", W'(sram_raddr), W'(((r + 1) * (40 - BYP)) % 64));
      chk("wrap_empty", W'(fifo_empty), 1);
    end

    midop(1'b0);
    midop(1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
